sound_player: RTL and testbench

//  Consumer of the game-FSM sound request (soundselector + 1-cycle playsound).

---
 rtl/sound_player_if.sv | 29 ++
 rtl/sound_player.sv | 182 ++++++++++++++++++
 tb/tb_sound_player.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_player_if.sv
// Sound request bus between the game FSM (master) and the jingle player (slave).
//  soundselector : jingle select, sampled only while playsound is high
//  playsound     : one-cycle request strobe (also preempts a running jingle)
//  mute          : forces the speaker low without affecting sequencing
//  speaker       : registered square-wave output
//  busy          : registered, high while a jingle is sounding or in a gap
interface sound_player_if;
    logic [1:0] soundselector;
    logic       playsound;
    logic       mute;
    logic       speaker;
    logic       busy;

    modport master (
        output soundselector,
        output playsound,
        output mute,
        input  speaker,
        input  busy
    );

    modport slave (
        input  soundselector,
        input  playsound,
        input  mute,
        output speaker,
        output busy
    );
endinterface

// File: rtl/sound_player.sv
// Jingle player: on a playsound strobe, plays the selected 1-4 note jingle as a
// square wave on a single-bit speaker pin, with silent gaps between notes.
// Ports:
//  clk   : system clock
//  reset : synchronous, active-high reset
//  bus   : sound_player_if.slave (soundselector, playsound, mute in; speaker, busy out)
module sound_player #(
    parameter int unsigned CLK_HZ      = 25_000_000,
    parameter int unsigned NOTE_CYCLES = 2_500_000,
    parameter int unsigned GAP_CYCLES  = 250_000
) (
    input  logic                 clk,
    input  logic                 reset,
    sound_player_if.slave        bus
);

    // Half-periods of every note frequency used by the jingle tables
    localparam int unsigned HALF_262  = CLK_HZ / (2 * 262);
    localparam int unsigned HALF_330  = CLK_HZ / (2 * 330);
    localparam int unsigned HALF_392  = CLK_HZ / (2 * 392);
    localparam int unsigned HALF_523  = CLK_HZ / (2 * 523);
    localparam int unsigned HALF_659  = CLK_HZ / (2 * 659);
    localparam int unsigned HALF_784  = CLK_HZ / (2 * 784);
    localparam int unsigned HALF_1047 = CLK_HZ / (2 * 1047);

    // The lowest note has the longest half-period
    localparam int unsigned HALF_W = $clog2(HALF_262 + 1);
    localparam int unsigned DUR_W  = $clog2(NOTE_CYCLES);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_sel;
    logic [1:0]          r_idx;
    logic [HALF_W-1:0]   r_half_cnt;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_phase;
    logic                r_speaker;
    logic                r_busy;

    state_t              w_state_nx;
    logic [1:0]          w_sel_nx;
    logic [1:0]          w_idx_nx;
    logic [HALF_W-1:0]   w_half_cnt_nx;
    logic [DUR_W-1:0]    w_dur_cnt_nx;
    logic [GAP_W-1:0]    w_gap_cnt_nx;
    logic                w_phase_nx;
    logic                w_speaker_nx;
    logic                w_busy_nx;

    logic [HALF_W-1:0]   w_half;
    logic                w_note_end;
    logic                w_gap_end;
    logic                w_last_note;
    logic                w_half_end;

    // Half-period of the current note; jingle n has sel+1 notes
    always_comb begin
        w_half = HALF_W'(HALF_1047);
        case ({r_sel, r_idx})
            4'b00_00: w_half = HALF_W'(HALF_1047);
            4'b01_00: w_half = HALF_W'(HALF_523);
            4'b01_01: w_half = HALF_W'(HALF_784);
            4'b10_00: w_half = HALF_W'(HALF_392);
            4'b10_01: w_half = HALF_W'(HALF_330);
            4'b10_10: w_half = HALF_W'(HALF_262);
            4'b11_00: w_half = HALF_W'(HALF_523);
            4'b11_01: w_half = HALF_W'(HALF_659);
            4'b11_10: w_half = HALF_W'(HALF_784);
            4'b11_11: w_half = HALF_W'(HALF_1047);
            default:  w_half = HALF_W'(HALF_1047);
        endcase
    end

    assign w_note_end  = (r_state == ST_TONE) && (r_dur_cnt == DUR_W'(NOTE_CYCLES - 1));
    assign w_gap_end   = (r_state == ST_GAP)  && (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign w_last_note = (r_idx == r_sel);
    assign w_half_end  = (r_half_cnt == w_half - HALF_W'(1));

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sel      <= 2'd0;
            r_idx      <= 2'd0;
            r_half_cnt <= '0;
            r_dur_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_phase    <= 1'b0;
            r_speaker  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sel      <= w_sel_nx;
            r_idx      <= w_idx_nx;
            r_half_cnt <= w_half_cnt_nx;
            r_dur_cnt  <= w_dur_cnt_nx;
            r_gap_cnt  <= w_gap_cnt_nx;
            r_phase    <= w_phase_nx;
            r_speaker  <= w_speaker_nx;
            r_busy     <= w_busy_nx;
        end
    end

    // Next-state logic; a request always (re)starts the jingle, even on its last cycle
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: w_state_nx = ST_IDLE;
            ST_TONE: if (w_note_end) w_state_nx = w_last_note ? ST_IDLE : ST_GAP;
            ST_GAP:  if (w_gap_end)  w_state_nx = ST_TONE;
            default: w_state_nx = ST_IDLE;
        endcase
        if (bus.playsound) begin
            w_state_nx = ST_TONE;
        end
    end

    // Counters, phase and registered outputs
    always_comb begin
        w_sel_nx      = r_sel;
        w_idx_nx      = r_idx;
        w_half_cnt_nx = r_half_cnt;
        w_dur_cnt_nx  = r_dur_cnt;
        w_gap_cnt_nx  = r_gap_cnt;
        w_phase_nx    = r_phase;

        if (bus.playsound) begin
            w_sel_nx      = bus.soundselector;
            w_idx_nx      = 2'd0;
            w_half_cnt_nx = '0;
            w_dur_cnt_nx  = '0;
            w_gap_cnt_nx  = '0;
            w_phase_nx    = 1'b0;
        end else begin
            case (r_state)
                ST_TONE: begin
                    if (w_note_end) begin
                        w_half_cnt_nx = '0;
                        w_dur_cnt_nx  = '0;
                        w_gap_cnt_nx  = '0;
                        w_phase_nx    = 1'b0;
                    end else begin
                        w_dur_cnt_nx = r_dur_cnt + DUR_W'(1);
                        if (w_half_end) begin
                            w_half_cnt_nx = '0;
                            w_phase_nx    = ~r_phase;
                        end else begin
                            w_half_cnt_nx = r_half_cnt + HALF_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        w_gap_cnt_nx  = '0;
                        w_idx_nx      = r_idx + 2'd1;
                        w_half_cnt_nx = '0;
                        w_dur_cnt_nx  = '0;
                        w_phase_nx    = 1'b0;
                    end else begin
                        w_gap_cnt_nx = r_gap_cnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // Outputs are computed from next-state values so they line up with the state
        w_speaker_nx = w_phase_nx & ~bus.mute & (w_state_nx == ST_TONE);
        w_busy_nx    = (w_state_nx != ST_IDLE);
    end

    assign bus.speaker = r_speaker;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_sound_player.sv
// Self-checking bench for sound_player: scenario tasks plus randomized traffic,
// checked every cycle against a time-offset reference model of the jingles.
module tb_sound_player;

    localparam int unsigned CLK_HZ = 100_000;
    localparam int unsigned NOTE   = 1000;
    localparam int unsigned GAP    = 100;

    logic clk;
    logic reset;
    sound_player_if bus ();

    sound_player #(
        .CLK_HZ      (CLK_HZ),
        .NOTE_CYCLES (NOTE),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned freq_tab [4][4] = '{
        '{1047,    0,    0,    0},
        '{ 523,  784,    0,    0},
        '{ 392,  330,  262,    0},
        '{ 523,  659,  784, 1047}
    };

    int n_cmp;
    int n_err;

    // Reference model: jingle selection and cycles elapsed since the request took effect
    bit m_active;
    int m_sel;
    int m_t;
    bit e_spk;
    bit e_busy;

    function automatic int total_of(input int s);
        return (s + 1) * NOTE + s * GAP;
    endfunction

    // Drive one cycle of inputs, clock it, update the model, sample #1 after the edge
    task automatic step(input bit rst, input bit ps, input logic [1:0] sel, input bit mu);
        int k;
        int w;
        int half;
        reset             = rst;
        bus.playsound     = ps;
        bus.soundselector = sel;
        bus.mute          = mu;
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0;
        end else if (ps) begin
            m_active = 1'b1;
            m_sel    = int'(sel);
            m_t      = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t >= total_of(m_sel)) m_active = 1'b0;
        end
        e_busy = m_active;
        e_spk  = 1'b0;
        if (m_active) begin
            k = m_t / (NOTE + GAP);
            w = m_t % (NOTE + GAP);
            if (w < NOTE) begin
                half  = CLK_HZ / (2 * freq_tab[m_sel][k]);
                e_spk = ((w / half) % 2 == 1) && !mu;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
            n_cmp++;
            if (bus.speaker !== 1'b0) begin
                n_err++; $display("FAIL reset_speaker cyc=%0d got %b exp 0", i, bus.speaker);
            end
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_err++; $display("FAIL reset_busy cyc=%0d got %b exp 0", i, bus.busy);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_err++; $display("FAIL idle_busy cyc=%0d got %b exp 0", i, bus.busy);
            end
        end
    endtask

    task automatic test_sel0();
        int busy_cnt;
        int rise;
        step(1'b0, 1'b1, 2'd0, 1'b0);
        busy_cnt = int'(bus.busy);
        rise     = -1;
        for (int i = 1; i <= 1100; i++) begin
            step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
            busy_cnt += int'(bus.busy);
            if (bus.speaker === 1'b1 && rise < 0) rise = i;
            n_cmp++;
            if (bus.speaker !== e_spk || bus.busy !== e_busy) begin
                n_err++; $display("FAIL sel0 t=%0d spk got %b exp %b busy got %b exp %b",
                                  i, bus.speaker, e_spk, bus.busy, e_busy);
            end
        end
        n_cmp++;
        if (busy_cnt != 1000) begin
            n_err++; $display("FAIL sel0_busy_len got %0d exp 1000", busy_cnt);
        end
        n_cmp++;
        if (rise != 47) begin
            n_err++; $display("FAIL sel0_first_rise got %0d exp 47", rise);
        end
        n_cmp++;
        if (bus.speaker !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL sel0_idle spk=%b busy=%b exp 0/0", bus.speaker, bus.busy);
        end
    endtask

    task automatic test_sel3();
        int busy_cnt;
        step(1'b0, 1'b1, 2'd3, 1'b0);
        busy_cnt = int'(bus.busy);
        for (int i = 1; i <= 4400; i++) begin
            step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
            busy_cnt += int'(bus.busy);
            n_cmp++;
            if (bus.speaker !== e_spk || bus.busy !== e_busy) begin
                n_err++; $display("FAIL sel3 t=%0d spk got %b exp %b busy got %b exp %b",
                                  i, bus.speaker, e_spk, bus.busy, e_busy);
            end
        end
        n_cmp++;
        if (busy_cnt != 4300) begin
            n_err++; $display("FAIL sel3_busy_len got %0d exp 4300", busy_cnt);
        end
    endtask

    task automatic test_preempt();
        int busy_cnt;
        int drops;
        step(1'b0, 1'b1, 2'd2, 1'b0);
        busy_cnt = int'(bus.busy);
        drops    = 0;
        for (int i = 1; i <= 3700; i++) begin
            step(1'b0, (i == 1500), (i == 1500) ? 2'd1 : 2'($urandom_range(0, 3)), 1'b0);
            busy_cnt += int'(bus.busy);
            if (i < 3600 && bus.busy !== 1'b1) drops++;
            n_cmp++;
            if (bus.speaker !== e_spk || bus.busy !== e_busy) begin
                n_err++; $display("FAIL preempt t=%0d spk got %b exp %b busy got %b exp %b",
                                  i, bus.speaker, e_spk, bus.busy, e_busy);
            end
        end
        n_cmp++;
        if (busy_cnt != 3600 || drops != 0) begin
            n_err++; $display("FAIL preempt_busy len=%0d drops=%0d exp 3600/0", busy_cnt, drops);
        end
    endtask

    task automatic test_mute();
        int busy_cnt;
        int muted_high;
        bit mu;
        step(1'b0, 1'b1, 2'd1, 1'b1);
        busy_cnt   = int'(bus.busy);
        muted_high = 0;
        for (int i = 1; i <= 2200; i++) begin
            mu = (i < 1600);
            step(1'b0, 1'b0, 2'($urandom_range(0, 3)), mu);
            busy_cnt += int'(bus.busy);
            if (mu && bus.speaker !== 1'b0) muted_high++;
            n_cmp++;
            if (bus.speaker !== e_spk || bus.busy !== e_busy) begin
                n_err++; $display("FAIL mute t=%0d spk got %b exp %b busy got %b exp %b",
                                  i, bus.speaker, e_spk, bus.busy, e_busy);
            end
        end
        n_cmp++;
        if (busy_cnt != 2100 || muted_high != 0) begin
            n_err++; $display("FAIL mute_summary busy=%0d muted_high=%0d exp 2100/0",
                              busy_cnt, muted_high);
        end
    endtask

    task automatic test_end_restart();
        int busy_cnt;
        int drops;
        step(1'b0, 1'b1, 2'd0, 1'b0);
        busy_cnt = int'(bus.busy);
        drops    = 0;
        for (int i = 1; i <= 2100; i++) begin
            step(1'b0, (i == 1000), 2'd0, 1'b0);
            busy_cnt += int'(bus.busy);
            if (i < 2000 && bus.busy !== 1'b1) drops++;
            n_cmp++;
            if (bus.speaker !== e_spk || bus.busy !== e_busy) begin
                n_err++; $display("FAIL end_restart t=%0d spk got %b exp %b busy got %b exp %b",
                                  i, bus.speaker, e_spk, bus.busy, e_busy);
            end
        end
        n_cmp++;
        if (busy_cnt != 2000 || drops != 0) begin
            n_err++; $display("FAIL end_restart_busy len=%0d drops=%0d exp 2000/0", busy_cnt, drops);
        end
    endtask

    task automatic test_random();
        bit mu;
        bit ps;
        mu = 1'b0;
        for (int i = 0; i < 25000; i++) begin
            if ($urandom_range(0, 499) == 0) mu = ~mu;
            ps = ($urandom_range(0, 1499) == 0);
            step(1'b0, ps, 2'($urandom_range(0, 3)), mu);
            n_cmp++;
            if (bus.speaker !== e_spk || bus.busy !== e_busy) begin
                n_err++; $display("FAIL random cyc=%0d spk got %b exp %b busy got %b exp %b",
                                  i, bus.speaker, e_spk, bus.busy, e_busy);
            end
        end
        // Finish with a reset in the middle of whatever is playing
        step(1'b1, 1'b0, 2'd0, 1'b0);
        n_cmp++;
        if (bus.speaker !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL random_reset spk=%b busy=%b exp 0/0", bus.speaker, bus.busy);
        end
    endtask

    initial begin
        n_cmp             = 0;
        n_err             = 0;
        m_active          = 1'b0;
        m_sel             = 0;
        m_t               = 0;
        reset             = 1'b1;
        bus.playsound     = 1'b0;
        bus.soundselector = 2'd0;
        bus.mute          = 1'b0;
        test_reset();
        test_sel0();
        test_sel3();
        test_preempt();
        test_mute();
        test_end_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
